// File: rtl/mpeg_pixel_out_if.sv
// Decoder pixel/sync bundle into the output stage, plus the video and diagnostic
// signals it drives back out toward the core.
interface mpeg_pixel_out_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 12
);
  logic [1:0]       mode_req;
  logic [7:0]       in_r, in_g, in_b, in_y;
  logic             pixel_en, h_sync, v_sync, err_clr;
  logic [DW-1:0]    r, g, b;
  logic             de, hs, vs;
  logic [1:0]       mode_act;
  logic [CNT_W-1:0] x_pos, y_pos, last_len;
  logic             line_err;
  logic [15:0]      frame_cnt;

  modport master (
    output mode_req, in_r, in_g, in_b, in_y, pixel_en, h_sync, v_sync, err_clr,
    input  r, g, b, de, hs, vs, mode_act, x_pos, y_pos, last_len, line_err, frame_cnt
  );

  modport slave (
    input  mode_req, in_r, in_g, in_b, in_y, pixel_en, h_sync, v_sync, err_clr,
    output r, g, b, de, hs, vs, mode_act, x_pos, y_pos, last_len, line_err, frame_cnt
  );
endinterface

// File: rtl/mpeg_pixel_out.sv
// Two-stage pixel output stage: register decoder pixels/syncs, pick the colour source,
// widen or narrow to DW, and keep raster/line-length diagnostics for underrun hunting.

module mpeg_pixel_out_lane #(
  parameter int DW = 8
) (
  input  logic [7:0]    c_i,
  output logic [DW-1:0] c_o
);
  // Widening repeats the top bits so full-scale stays full-scale.
  generate
    if (DW == 8) begin : g_pass
      assign c_o = c_i;
    end else if (DW > 8) begin : g_wide
      assign c_o = {c_i, c_i[7 -: (DW-8)]};
    end else begin : g_narrow
      assign c_o = c_i[7 -: DW];
    end
  endgenerate
endmodule

module mpeg_pixel_out #(
  parameter int          DW         = 8,
  parameter int          H_ACTIVE   = 720,
  parameter int          CNT_W      = 12,
  parameter logic [23:0] BORDER_RGB = 24'h444444,
  parameter logic [23:0] SYNC_RGB   = 24'hFF00FF
) (
  input  logic       dot_clk,
  input  logic       RESET_N,
  mpeg_pixel_out_if.slave pix
);
  localparam int               NCH     = 3;
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] BW_C    = CNT_W'(H_ACTIVE / 8);
  localparam logic [CNT_W-1:0] X_MAX   = '1;

  // stage 1
  logic [7:0]       r1_q, g1_q, b1_q, y1_q;
  logic             pe1_q, hs1_q, vs1_q;
  logic [2:0]       bar1_q;
  logic [CNT_W-1:0] xi1_q;

  // raster / diagnostic state
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [CNT_W-1:0] last_len_q, last_len_d;
  logic             line_err_q, line_err_d;
  logic [15:0]      frame_q, frame_d;
  logic [1:0]       mode_q, mode_d;

  // stage 2
  logic [DW-1:0]    r_q, g_q, b_q;
  logic             de_q, hs_q, vs_q;
  logic [CNT_W-1:0] x_pos_q;

  logic hs_rise, vs_rise, line_set;
  logic [NCH-1:0][7:0]    sel_c;
  logic [NCH-1:0][DW-1:0] cvt_c;
  logic [23:0]            bar_rgb;

  assign hs_rise = pix.h_sync & ~hs1_q;
  assign vs_rise = pix.v_sync & ~vs1_q;

  // Line close reads the pre-clear count; a frame start then overrides the y step.
  always_comb begin
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    bar_pix_d  = bar_pix_q;
    bar_idx_d  = bar_idx_q;
    last_len_d = last_len_q;
    line_err_d = line_err_q;
    frame_d    = frame_q;
    mode_d     = mode_q;
    line_set   = 1'b0;
    if (hs_rise) begin
      x_cnt_d   = '0;
      bar_pix_d = '0;
      bar_idx_d = '0;
      if (x_cnt_q != '0) begin
        last_len_d = x_cnt_q;
        line_set   = (x_cnt_q != H_ACT_C);
        y_cnt_d    = y_cnt_q + 1'b1;
      end
    end else if (pix.pixel_en) begin
      if (x_cnt_q != X_MAX) x_cnt_d = x_cnt_q + 1'b1;
      if (bar_pix_q == BW_C - 1'b1) begin
        bar_pix_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
      end
    end
    if (vs_rise) begin
      y_cnt_d = '0;
      frame_d = frame_q + 16'd1;
      mode_d  = pix.mode_req;
    end
    if (line_set)         line_err_d = 1'b1;
    else if (pix.err_clr) line_err_d = 1'b0;
  end

  always_ff @(posedge dot_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r1_q       <= '0;
      g1_q       <= '0;
      b1_q       <= '0;
      y1_q       <= '0;
      pe1_q      <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      bar1_q     <= '0;
      xi1_q      <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      bar_pix_q  <= '0;
      bar_idx_q  <= '0;
      last_len_q <= '0;
      line_err_q <= 1'b0;
      frame_q    <= '0;
      mode_q     <= '0;
    end else begin
      r1_q       <= pix.in_r;
      g1_q       <= pix.in_g;
      b1_q       <= pix.in_b;
      y1_q       <= pix.in_y;
      pe1_q      <= pix.pixel_en;
      hs1_q      <= pix.h_sync;
      vs1_q      <= pix.v_sync;
      bar1_q     <= hs_rise ? 3'd0 : bar_idx_q;
      xi1_q      <= hs_rise ? '0 : x_cnt_q;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      bar_pix_q  <= bar_pix_d;
      bar_idx_q  <= bar_idx_d;
      last_len_q <= last_len_d;
      line_err_q <= line_err_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
    end
  end

  // Bar k: red off for k[1], green off for k[2], blue off for k[0].
  assign bar_rgb = {{8{~bar1_q[1]}}, {8{~bar1_q[2]}}, {8{~bar1_q[0]}}};

  always_comb begin
    sel_c = {r1_q, g1_q, b1_q};
    if (mode_q == 2'd3 && (hs1_q || vs1_q)) begin
      sel_c = SYNC_RGB;
    end else if (!pe1_q) begin
      sel_c = BORDER_RGB;
    end else begin
      case (mode_q)
        2'd1:    sel_c = {y1_q, y1_q, y1_q};
        2'd2:    sel_c = bar_rgb;
        default: sel_c = {r1_q, g1_q, b1_q};
      endcase
    end
`ifndef SYNTHESIS
    // Make undriven decoder data impossible to miss on screen.
    if (pe1_q && $isunknown({r1_q, g1_q, b1_q})) sel_c = 24'hFF0000;
`endif
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    mpeg_pixel_out_lane #(.DW(DW)) u_lane (
      .c_i (sel_c[i]),
      .c_o (cvt_c[i])
    );
  end

  always_ff @(posedge dot_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      x_pos_q <= '0;
    end else begin
      r_q     <= cvt_c[2];
      g_q     <= cvt_c[1];
      b_q     <= cvt_c[0];
      de_q    <= pe1_q;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      x_pos_q <= xi1_q;
    end
  end

  assign pix.r         = r_q;
  assign pix.g         = g_q;
  assign pix.b         = b_q;
  assign pix.de        = de_q;
  assign pix.hs        = hs_q;
  assign pix.vs        = vs_q;
  assign pix.mode_act  = mode_q;
  assign pix.x_pos     = x_pos_q;
  assign pix.y_pos     = y_cnt_q;
  assign pix.last_len  = last_len_q;
  assign pix.line_err  = line_err_q;
  assign pix.frame_cnt = frame_q;
endmodule

// File: tb/tb_mpeg_pixel_out.sv
// Directed bench: DW=8 instance streams whole lines against a small colour model;
// a DW=10 instance covers width expansion and x-counter saturation.
module tb_mpeg_pixel_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpeg_pixel_out_if #(.DW(8),  .CNT_W(12)) m8 ();
  mpeg_pixel_out_if #(.DW(10), .CNT_W(12)) m10 ();

  mpeg_pixel_out #(.DW(8))  u8  (.dot_clk(clk), .RESET_N(rst_n), .pix(m8));
  mpeg_pixel_out #(.DW(10)) u10 (.dot_clk(clk), .RESET_N(rst_n), .pix(m10));

  int checks = 0;
  int errors = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int unsigned xcnt;
  logic [1:0]  mmode;
  logic        hs_p, vs_p;
  logic [38:0] e1, e2;
  bit          e1v, e2v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    xcnt = 0; mmode = 2'd0; hs_p = 1'b0; vs_p = 1'b0;
    e1 = '0; e2 = '0; e1v = 1'b0; e2v = 1'b0;
  endtask

  // One dot clock on the DW=8 instance: check the output due now, drive, predict.
  task automatic step(input logic pe, input logic hs, input logic vs);
    logic [23:0] c;
    logic [7:0]  ir, iy;
    int          bi;
    if (e2v) chk("pix", {m8.r, m8.g, m8.b, m8.de, m8.hs, m8.vs, m8.x_pos}, {25'd0, e2});
    ir = 8'(12 + xcnt);
    iy = 8'(xcnt) ^ 8'h5A;
    m8.pixel_en = pe; m8.h_sync = hs; m8.v_sync = vs;
    m8.in_r = ir; m8.in_g = 8'd34; m8.in_b = 8'd56; m8.in_y = iy;
    if (vs && !vs_p) mmode = m8.mode_req;
    if (hs && !hs_p) xcnt = 0;
    bi = int'(xcnt / 90);
    if (bi > 7) bi = 7;
    if (mmode == 2'd3 && (hs || vs)) c = 24'hFF00FF;
    else if (!pe)                    c = 24'h444444;
    else if (mmode == 2'd1)          c = {iy, iy, iy};
    else if (mmode == 2'd2)          c = bars[bi];
    else                             c = {ir, 8'd34, 8'd56};
    e2 = e1; e2v = e1v;
    e1 = {c, pe, hs, vs, 12'(xcnt)}; e1v = 1'b1;
    if (pe && !(hs && !hs_p) && xcnt < 4095) xcnt++;
    hs_p = hs; vs_p = vs;
    @(negedge clk);
  endtask

  // hsync (optionally with vsync) x3, back porch x3, npix active, front porch x3.
  task automatic line(input int npix, input logic vsf, input logic clr,
                      input logic [11:0] elen, input logic eerr,
                      input logic [11:0] ey, input logic [15:0] ef);
    m8.err_clr = clr;
    step(1'b0, 1'b1, vsf);
    m8.err_clr = 1'b0;
    chk("last_len", m8.last_len, elen);
    chk("line_err", m8.line_err, eerr);
    chk("y_pos", m8.y_pos, ey);
    chk("frame_cnt", m8.frame_cnt, ef);
    step(1'b0, 1'b1, vsf);
    step(1'b0, 1'b1, vsf);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < npix; i++) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m8.mode_req = 2'd0; m8.in_r = '0; m8.in_g = '0; m8.in_b = '0; m8.in_y = '0;
    m8.pixel_en = 1'b0; m8.h_sync = 1'b0; m8.v_sync = 1'b0; m8.err_clr = 1'b0;
    m10.mode_req = 2'd0; m10.in_r = '0; m10.in_g = '0; m10.in_b = '0; m10.in_y = '0;
    m10.pixel_en = 1'b0; m10.h_sync = 1'b0; m10.v_sync = 1'b0; m10.err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pix", {m8.r, m8.g, m8.b, m8.de, m8.hs, m8.vs, m8.x_pos}, 64'd0);
    chk("rst_cnt", {m8.y_pos, m8.last_len, m8.line_err, m8.frame_cnt, m8.mode_act}, 64'd0);
    chk("rst_pix10", {m10.r, m10.g, m10.b, m10.de, m10.hs, m10.vs, m10.x_pos}, 64'd0);
    rst_n = 1'b1;

    // mode 0 lines: good, good, short, good
    line(720, 1'b1, 1'b0, 12'd0,   1'b0, 12'd0, 16'd1);
    chk("mode_act0", m8.mode_act, 2'd0);
    line(720, 1'b0, 1'b0, 12'd720, 1'b0, 12'd1, 16'd1);
    line(719, 1'b0, 1'b0, 12'd720, 1'b0, 12'd2, 16'd1);
    line(720, 1'b0, 1'b0, 12'd719, 1'b1, 12'd3, 16'd1);
    m8.err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    m8.err_clr = 1'b0;
    chk("err_clr", m8.line_err, 1'b0);
    line(720, 1'b0, 1'b0, 12'd720, 1'b0, 12'd4, 16'd1);
    line(700, 1'b0, 1'b0, 12'd720, 1'b0, 12'd5, 16'd1);
    // err_clr coincident with a bad-line close: set wins
    line(720, 1'b0, 1'b1, 12'd700, 1'b1, 12'd6, 16'd1);
    m8.err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    m8.err_clr = 1'b0;
    chk("err_clr2", m8.line_err, 1'b0);

    // mode request mid-frame waits for vsync
    m8.mode_req = 2'd2;
    line(720, 1'b0, 1'b0, 12'd720, 1'b0, 12'd7, 16'd1);
    chk("mode_hold", m8.mode_act, 2'd0);
    // vs_rise with hs_rise: close 720 line, y cleared, bars frame
    line(720, 1'b1, 1'b0, 12'd720, 1'b0, 12'd0, 16'd2);
    chk("mode_act2", m8.mode_act, 2'd2);
    m8.mode_req = 2'd3;
    line(720, 1'b1, 1'b0, 12'd720, 1'b0, 12'd0, 16'd3);
    chk("mode_act3", m8.mode_act, 2'd3);
    line(720, 1'b0, 1'b0, 12'd720, 1'b0, 12'd1, 16'd3);

    // DW=10, mode 1 grey expansion
    m10.mode_req = 2'd1; m10.v_sync = 1'b1;
    @(negedge clk);
    m10.v_sync = 1'b0; m10.pixel_en = 1'b1; m10.in_y = 8'hFF;
    @(negedge clk);
    m10.in_y = 8'h80;
    @(negedge clk);
    chk("mode_act10", m10.mode_act, 2'd1);
    chk("y_ff", {m10.r, m10.g, m10.b, m10.de}, {10'h3FF, 10'h3FF, 10'h3FF, 1'b1});
    m10.pixel_en = 1'b0;
    @(negedge clk);
    chk("y_80", {m10.r, m10.g, m10.b, m10.de}, {10'h202, 10'h202, 10'h202, 1'b1});
    @(negedge clk);
    chk("border10", {m10.r, m10.g, m10.b, m10.de}, {10'h111, 10'h111, 10'h111, 1'b0});

    // x counter saturation on a runaway line
    m10.pixel_en = 1'b1;
    repeat (4200) @(negedge clk);
    chk("x_sat", m10.x_pos, 12'hFFF);
    m10.pixel_en = 1'b0; m10.h_sync = 1'b1;
    @(negedge clk);
    chk("len_sat", {m10.last_len, m10.line_err, m10.y_pos}, {12'hFFF, 1'b1, 12'd1});
    m10.h_sync = 1'b0;

    // reset mid-line, then hsync must not flag an error
    repeat (3) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (100) step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pix", {m8.r, m8.g, m8.b, m8.de, m8.hs, m8.vs, m8.x_pos}, 64'd0);
    chk("rst_mid_cnt", {m8.y_pos, m8.last_len, m8.line_err, m8.frame_cnt, m8.mode_act}, 64'd0);
    chk("rst_mid_err10", m10.line_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m8.mode_req = 2'd0;
    model_reset();
    line(50, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
